// File: rtl/bk_pkg.sv
// Shared types for the Brent-Kung subtractor pipeline.
//   BK_W_MAX     widest supported operand
//   gp_t         generate/propagate pair for one bit or bit group
//   sweep_dir_t  selects the up-sweep or down-sweep half of the prefix tree
//   bk_combine   prefix operator: (hi) o (lo), hi is the more significant group
//   stage_t      S1/S2 payload: gp vector, raw propagate, carry-in, operand signs
package bk_pkg;

  localparam int BK_W_MAX = 64;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  typedef enum logic {SWEEP_UP, SWEEP_DOWN} sweep_dir_t;

  function automatic gp_t bk_combine(gp_t hi, gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // Vectors sized for the widest build; narrower builds use the low WIDTH bits.
  // p keeps the per-bit propagate untouched by the tree, needed for the sum.
  typedef struct packed {
    gp_t [BK_W_MAX-1:0]  gp;
    logic [BK_W_MAX-1:0] p;
    logic                cin;
    logic                sa;
    logic                sb;
  } stage_t;

endpackage

// File: rtl/bk_prefix_sweep.sv
// Combinational half of a Brent-Kung prefix tree.
//   DIR=SWEEP_UP   : log2(WIDTH) levels, spans 1,2,4..WIDTH/2; node i with
//                    (i+1) a multiple of 2*span absorbs node i-span.
//   DIR=SWEEP_DOWN : log2(WIDTH)-1 levels, spans WIDTH/4..1; fills the
//                    remaining nodes so every y[i] is the prefix over [i:0].
// Ports:
//   x  in   WIDTH gp pairs
//   y  out  WIDTH gp pairs after this half of the tree
import bk_pkg::*;

module bk_prefix_sweep #(
  parameter int         WIDTH = 64,
  parameter sweep_dir_t DIR   = SWEEP_UP
) (
  input  gp_t [WIDTH-1:0] x,
  output gp_t [WIDTH-1:0] y
);

  localparam int LOG  = $clog2(WIDTH);
  localparam int NLVL = (DIR == SWEEP_UP) ? LOG : LOG - 1;

  for (genvar s = 0; s < NLVL; s++) begin : g_lvl
    localparam int L    = (DIR == SWEEP_UP) ? s : LOG - 2 - s;
    localparam int SPAN = 1 << L;
    gp_t [WIDTH-1:0] src;
    gp_t [WIDTH-1:0] t;

    if (s == 0) begin : g_src0
      assign src = x;
    end else begin : g_srcn
      assign src = g_lvl[s-1].t;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_node
      localparam bit HIT = (DIR == SWEEP_UP) ?
                           (((i + 1) % (2 * SPAN)) == 0) :
                           ((i >= 3 * SPAN - 1) && (((i + 1) % (2 * SPAN)) == SPAN));
      if (HIT) begin : g_op
        assign t[i] = bk_combine(src[i], src[i-SPAN]);
      end else begin : g_pass
        assign t[i] = src[i];
      end
    end
  end

  assign y = g_lvl[NLVL-1].t;

endmodule

// File: rtl/bk_subtractor_pipe.sv
// Three-stage Brent-Kung subtractor: diff = a - b - borrow_in, computed as
// a + ~b + ~borrow_in, reporting borrow (inverted carry).
//   S1: g/p of a,~b and cin; S2: up-sweep; S3: down-sweep, sum, flags.
// Optional build macro BK_SUB_SATURATE_EN: clamp diff to the signed extreme
// on overflow (neg/zero follow the clamped value, ovf stays raw).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake; a, b, borrow_in payload
//   out_valid/out_ready   result handshake; diff, borrow_out, zero, neg, ovf
import bk_pkg::*;

module bk_subtractor_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  if (WIDTH < 8 || WIDTH > BK_W_MAX || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("bk_subtractor_pipe: WIDTH must be a power of two in 8..64");
  end

  localparam int STAGES = 3;

  logic [STAGES:1] vld_pipe;
  logic            ld1, ld2, ld3;
  stage_t          s1, s1_d, s2, s2_d;

  // A stage loads when empty or when its contents move on this cycle.
  assign ld3       = !vld_pipe[3] | out_ready;
  assign ld2       = !vld_pipe[2] | ld3;
  assign ld1       = !vld_pipe[1] | ld2;
  assign in_ready  = ld1;
  assign out_valid = vld_pipe[3];

  // S1 input: g = a & ~b, p = a ^ ~b
  gp_t [WIDTH-1:0] leaf;
  for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
    assign leaf[i].g = a[i] & ~b[i];
    assign leaf[i].p = ~(a[i] ^ b[i]);
  end

  always_comb begin
    s1_d               = '0;
    s1_d.gp[WIDTH-1:0] = leaf;
    s1_d.p[WIDTH-1:0]  = ~(a ^ b);
    s1_d.cin           = ~borrow_in;
    s1_d.sa            = a[WIDTH-1];
    s1_d.sb            = b[WIDTH-1];
  end

  // S2 input: fold cin into bit 0 so every group generate includes it.
  gp_t [WIDTH-1:0] up_in, up_out;
  always_comb begin
    up_in      = s1.gp[WIDTH-1:0];
    up_in[0].g = s1.gp[0].g | (s1.gp[0].p & s1.cin);
  end

  bk_prefix_sweep #(.WIDTH(WIDTH), .DIR(SWEEP_UP)) u_up (
    .x (up_in),
    .y (up_out)
  );

  always_comb begin
    s2_d               = s1;
    s2_d.gp[WIDTH-1:0] = up_out;
  end

  // S3 input: full prefixes, carries, raw sum and flags.
  gp_t [WIDTH-1:0]  pre;
  logic [WIDTH-1:0] carry, raw, pre_p, diff_d;
  logic             ovf_d;
  logic             unused_pre_p;

  bk_prefix_sweep #(.WIDTH(WIDTH), .DIR(SWEEP_DOWN)) u_down (
    .x (s2.gp[WIDTH-1:0]),
    .y (pre)
  );

  assign carry[0] = s2.cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    if (i > 0) begin : g_c
      assign carry[i] = pre[i-1].g;
    end
    assign pre_p[i] = pre[i].p;
  end
  // Group propagates out of the tree are not needed once carries exist.
  assign unused_pre_p = ^pre_p;

  assign raw = s2.p[WIDTH-1:0] ^ carry;

`ifdef BK_SUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  always_comb begin
    ovf_d  = (s2.sa != s2.sb) && (raw[WIDTH-1] != s2.sa);
    diff_d = raw;
`ifdef BK_SUB_SATURATE_EN
    if (ovf_d) diff_d = s2.sa ? SAT_NEG : SAT_POS;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      s1         <= '0;
      s2         <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
      neg        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (ld1) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1 <= s1_d;
      end
      if (ld2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2 <= s2_d;
      end
      if (ld3) begin
        vld_pipe[3] <= vld_pipe[2];
        if (vld_pipe[2]) begin
          diff       <= diff_d;
          borrow_out <= ~pre[WIDTH-1].g;
          zero       <= (diff_d == '0);
          neg        <= diff_d[WIDTH-1];
          ovf        <= ovf_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// Directed and random checks of bk_subtractor_pipe (WIDTH=64).
module tb_bk_subtractor_pipe;

  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         borrow_in = 1'b0;
  logic         out_valid, out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         borrow_out, zero, neg, ovf;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo, z, n, o;
  } res_t;

  typedef struct packed {
    logic [W-1:0] a, b;
    logic         bi;
    res_t         e;
  } vec_t;

  bk_subtractor_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out),
    .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    res_t         e;
    logic [W:0]   r;
    r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    e.o  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    e.d  = r[W-1:0];
`ifdef BK_SUB_SATURATE_EN
    if (e.o) e.d = x[W-1] ? MINV : MAXV;
`endif
    e.bo = r[W];
    e.z  = (e.d == '0);
    e.n  = e.d[W-1];
    return e;
  endfunction

  // One clock: sample handshakes and payload at negedge, return 1ns past posedge.
  task automatic tick(output logic ti, output logic to, output res_t r);
    @(negedge clk);
    ti   = in_valid && in_ready;
    to   = out_valid && out_ready;
    r.d  = diff;
    r.bo = borrow_out;
    r.z  = zero;
    r.n  = neg;
    r.o  = ovf;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] bp_a(input int k);
    return 64'(k) * 64'h0123_4567_89AB_CDEF;
  endfunction
  function automatic logic [W-1:0] bp_b(input int k);
    return 64'(5 - k) * 64'h1111_1111_1111_1111;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_vec++;
    if ({diff, borrow_out, zero, neg, ovf} !== '0) begin
      n_err++; $display("FAIL reset_payload: got %h %b%b%b%b want all 0", diff, borrow_out, zero, neg, ovf);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t tbl[7];
    logic ti, to;
    res_t r;
    int   n;
    tbl[0] = {64'd5, 64'd3, 1'b0, 64'd2, 4'b0000};
    tbl[1] = {64'd0, 64'd1, 1'b0, ONES, 4'b1010};
    tbl[2] = {64'h1234, 64'h1234, 1'b1, ONES, 4'b1010};
    tbl[3] = {64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'd0, 4'b0100};
`ifdef BK_SUB_SATURATE_EN
    tbl[4] = {MINV, 64'd1, 1'b0, MINV, 4'b0011};
    tbl[5] = {MAXV, ONES, 1'b0, MAXV, 4'b1001};
`else
    tbl[4] = {MINV, 64'd1, 1'b0, MAXV, 4'b0001};
    tbl[5] = {MAXV, ONES, 1'b0, MINV, 4'b1011};
`endif
    tbl[6] = {64'd0, 64'd0, 1'b1, ONES, 4'b1010};
    out_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      a = tbl[v].a; b = tbl[v].b; borrow_in = tbl[v].bi; in_valid = 1'b1;
      tick(ti, to, r);
      n_vec++;
      if (ti !== 1'b1) begin
        n_err++; $display("FAIL dir%0d_accept: got %b want 1", v, ti);
      end
      in_valid = 1'b0;
      n = 0; to = 1'b0;
      while (!to && n < 10) begin
        tick(ti, to, r);
        n++;
      end
      n_vec++;
      if (n != 3) begin
        n_err++; $display("FAIL dir%0d_latency: got %0d cycles want 3", v, n);
      end
      n_vec++;
      if (r.d !== tbl[v].e.d) begin
        n_err++; $display("FAIL dir%0d_diff: got %h want %h", v, r.d, tbl[v].e.d);
      end
      n_vec++;
      if ({r.bo, r.z, r.n, r.o} !== {tbl[v].e.bo, tbl[v].e.z, tbl[v].e.n, tbl[v].e.o}) begin
        n_err++; $display("FAIL dir%0d_flags(bo,z,n,o): got %b%b%b%b want %b%b%b%b", v,
                          r.bo, r.z, r.n, r.o, tbl[v].e.bo, tbl[v].e.z, tbl[v].e.n, tbl[v].e.o);
      end
    end
  endtask

  task automatic test_backpressure();
    logic ti, to;
    res_t r, e;
    int   k, outs, cyc, extra;
    k = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (k < 6); a = bp_a(k); b = bp_b(k); borrow_in = k[0];
      tick(ti, to, r);
      if (ti) k++;
    end
    n_vec++;
    if (k != 3) begin
      n_err++; $display("FAIL bp_accepted: got %0d want 3", k);
    end
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    outs = 0; cyc = 0;
    while (outs < 6 && cyc < 40) begin
      in_valid = (k < 6); a = bp_a(k); b = bp_b(k); borrow_in = k[0];
      tick(ti, to, r);
      if (ti) k++;
      if (to) begin
        e = model(bp_a(outs), bp_b(outs), outs[0]);
        n_vec++;
        if (r !== e) begin
          n_err++; $display("FAIL bp_order%0d: got %h want %h", outs, r, e);
        end
        outs++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (outs != 6 || k != 6) begin
      n_err++; $display("FAIL bp_count: got out=%0d in=%0d want 6/6", outs, k);
    end
    extra = 0;
    repeat (5) begin
      tick(ti, to, r);
      if (to) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_err++; $display("FAIL bp_duplicate: got %0d extra beats want 0", extra);
    end
  endtask

  task automatic test_random();
    res_t q[$];
    logic ti, to;
    res_t r, e;
    int   sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 3000) begin
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      a         = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ MINV;
        default: b = {$urandom, $urandom};
      endcase
      borrow_in = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      tick(ti, to, r);
      if (ti) begin
        q.push_back(model(a, b, borrow_in));
        sent++;
      end
      if (to) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd_unexpected: got %h want no beat", r);
        end else begin
          e = q.pop_front();
          if (r !== e) begin
            n_err++; $display("FAIL rnd_beat%0d: got %h want %h", got, r, e);
          end
        end
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++;
    if (got != 100 || q.size() != 0) begin
      n_err++; $display("FAIL rnd_count: got %0d beats (%0d pending) want 100 (0)", got, q.size());
    end
  endtask

  task automatic test_mid_reset();
    logic ti, to;
    res_t r;
    int   n, stale;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick(ti, to, r);
    for (int k = 0; k < 2; k++) begin
      a = 64'd100 + 64'(k); b = 64'd7; borrow_in = 1'b0; in_valid = 1'b1;
      tick(ti, to, r);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick(ti, to, r);
    rst = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL mrst_out_valid: got %b want 0", out_valid);
    end
    n_vec++;
    if ({diff, borrow_out, zero, neg, ovf} !== '0) begin
      n_err++; $display("FAIL mrst_payload: got %h %b%b%b%b want all 0", diff, borrow_out, zero, neg, ovf);
    end
    stale = 0;
    repeat (6) begin
      tick(ti, to, r);
      if (to) stale++;
    end
    n_vec++;
    if (stale != 0) begin
      n_err++; $display("FAIL mrst_stale: got %0d beats want 0", stale);
    end
    a = 64'd10; b = 64'd4; borrow_in = 1'b1; in_valid = 1'b1;
    tick(ti, to, r);
    in_valid = 1'b0;
    n = 0; to = 1'b0;
    while (!to && n < 10) begin
      tick(ti, to, r);
      n++;
    end
    n_vec++;
    if (n != 3) begin
      n_err++; $display("FAIL mrst_latency: got %0d cycles want 3", n);
    end
    n_vec++;
    if (r !== {64'd5, 4'b0000}) begin
      n_err++; $display("FAIL mrst_result: got %h want %h", r, {64'd5, 4'b0000});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
